mcpu_bus: RTL and testbench

MCPU_BUS -- requirements
Module: mcpu_bus

---
 rtl/mcpu_bus.sv | 125 ++++++++++++
 tb/tb_mcpu_bus.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_bus.sv
// CPU-to-device bus bridge: one request at a time, routed to one of NREG regions by the top address bits.
// Request to cpu_ready takes 2+W cycles; requests arriving while busy are dropped and flagged in bus_ovr.
module mcpu_bus #(
   parameter int                           DATA_WIDTH  = 16,
   parameter int                           ADDR_WIDTH  = 16,
   parameter int                           SEL_BITS    = 2,
   parameter logic [4*(2**SEL_BITS)-1:0]   WAIT_STATES = '0,
   parameter logic [(2**SEL_BITS)-1:0]     RO_MASK     = '0
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [ADDR_WIDTH-1:0]                    cpu_addr,
   input  logic [DATA_WIDTH-1:0]                    cpu_wdata,
   input  logic                                     cpu_re,
   input  logic                                     cpu_we,
   output logic [DATA_WIDTH-1:0]                    cpu_rdata,
   output logic                                     cpu_ready,
   output logic [ADDR_WIDTH-SEL_BITS-1:0]           dev_addr,
   output logic [DATA_WIDTH-1:0]                    dev_wdata,
   output logic [(2**SEL_BITS)-1:0]                 dev_re,
   output logic [(2**SEL_BITS)-1:0]                 dev_we,
   input  logic [(2**SEL_BITS)*DATA_WIDTH-1:0]      dev_rdata,
   output logic                                     bus_err,
   output logic                                     bus_ovr,
   input  logic                                     err_clr
);

   localparam int NREG  = 2**SEL_BITS;
   localparam int OFS_W = ADDR_WIDTH - SEL_BITS;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   state_t              state;
   logic [SEL_BITS-1:0] region;
   logic                is_wr;
   logic [3:0]          wait_cnt;

   logic [SEL_BITS-1:0]   req_region;
   logic                  req;
   logic                  req_ro;
   logic [NREG-1:0]       req_onehot;
   logic [3:0]            region_ws;
   logic [DATA_WIDTH-1:0] region_rdata;
   logic                  finishing;
   logic                  err_set;
   logic                  ovr_set;

   always_comb begin
      req_region             = cpu_addr[ADDR_WIDTH-1 -: SEL_BITS];
      req                    = cpu_re | cpu_we;
      req_ro                 = RO_MASK[req_region];
      req_onehot             = '0;
      req_onehot[req_region] = 1'b1;
      region_ws              = WAIT_STATES[4*region +: 4];
      region_rdata           = dev_rdata[DATA_WIDTH*region +: DATA_WIDTH];
      // Last ACCESS/WAIT cycle: the edge that follows enters DONE.
      finishing              = ((state == ACCESS) && (region_ws == 4'd0)) ||
                               ((state == WAIT) && (wait_cnt == 4'd0));
      err_set                = (state == IDLE) && cpu_we && req_ro;
      ovr_set                = (state != IDLE) && req;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         region    <= '0;
         is_wr     <= 1'b0;
         wait_cnt  <= 4'd0;
         cpu_ready <= 1'b0;
         cpu_rdata <= '0;
         dev_re    <= '0;
         dev_we    <= '0;
         dev_addr  <= '0;
         dev_wdata <= '0;
         bus_err   <= 1'b0;
         bus_ovr   <= 1'b0;
      end else begin
         dev_re    <= '0;
         dev_we    <= '0;
         cpu_ready <= 1'b0;
         bus_err   <= err_set | (bus_err & ~err_clr);
         bus_ovr   <= ovr_set | (bus_ovr & ~err_clr);

         case (state)
            IDLE: begin
               if (req) begin
                  region    <= req_region;
                  dev_addr  <= cpu_addr[OFS_W-1:0];
                  dev_wdata <= cpu_wdata;
                  is_wr     <= cpu_we;
                  // A simultaneous read+write is a write; a write to a read-only region never strobes.
                  if (cpu_we) begin
                     if (!req_ro) dev_we <= req_onehot;
                  end else begin
                     dev_re <= req_onehot;
                  end
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               if (region_ws != 4'd0) begin
                  wait_cnt <= region_ws - 4'd1;
                  state    <= WAIT;
               end else begin
                  state <= DONE;
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) state <= DONE;
               else                  wait_cnt <= wait_cnt - 4'd1;
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (finishing) begin
            cpu_ready <= 1'b1;
            if (!is_wr) cpu_rdata <= region_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mcpu_bus.sv
// Scoreboard bench for mcpu_bus: the driver predicts strobes, completions and flags per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_mcpu_bus;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] cpu_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic        cpu_re = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;
   logic [13:0] dev_addr;
   logic [15:0] dev_wdata;
   logic [3:0]  dev_re;
   logic [3:0]  dev_we;
   logic [63:0] dev_rdata = '0;
   logic        bus_err;
   logic        bus_ovr;
   logic        err_clr = 1'b0;

   mcpu_bus #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (16),
      .SEL_BITS   (2),
      .WAIT_STATES(16'h1300),
      .RO_MASK    (4'b0010)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_re   (cpu_re),
      .cpu_we   (cpu_we),
      .cpu_rdata(cpu_rdata),
      .cpu_ready(cpu_ready),
      .dev_addr (dev_addr),
      .dev_wdata(dev_wdata),
      .dev_re   (dev_re),
      .dev_we   (dev_we),
      .dev_rdata(dev_rdata),
      .bus_err  (bus_err),
      .bus_ovr  (bus_ovr),
      .err_clr  (err_clr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [3:0] re; logic [3:0] we; logic [13:0] addr; logic [15:0] wdata; } st_t;
   typedef struct { int cyc; logic [15:0] rdata; logic [13:0] addr; logic [15:0] wdata; } rd_t;
   typedef struct { int cyc; logic err; logic ovr; logic rst; } fl_t;

   st_t st_q[$];
   rd_t rd_q[$];
   fl_t fl_q[$];

   int total = 0;
   int bad = 0;

   // Reference model state: region timing, last completed read, flags, end of current transaction.
   int          ws[4] = '{0, 0, 3, 1};
   logic [3:0]  ro = 4'b0010;
   logic [63:0] rd_tab[64];
   logic [15:0] last_rd = '0;
   logic        m_err = 1'b0;
   logic        m_ovr = 1'b0;
   int          busy_done = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input logic re, input logic we, input logic [15:0] a, input logic [15:0] wd,
                       input logic clr, input logic rst);
      int          c;
      int          r;
      int          done_c;
      logic        acc;
      logic [3:0]  oh;
      logic [63:0] t;
      @(posedge clk);
      #1;
      c         = cyc;
      cpu_re    = re;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = wd;
      err_clr   = clr;
      reset     = rst;
      dev_rdata = rd_tab[c % 64];
      if (rst) begin
         while (st_q.size() > 0 && st_q[$].cyc > c) void'(st_q.pop_back());
         while (rd_q.size() > 0 && rd_q[$].cyc > c) void'(rd_q.pop_back());
         busy_done = c;
         m_err     = 1'b0;
         m_ovr     = 1'b0;
         last_rd   = '0;
         fl_q.push_back('{c + 1, 1'b0, 1'b0, 1'b1});
      end else begin
         r   = int'(a[15:14]);
         oh  = 4'b0001 << r;
         acc = (re || we) && (c > busy_done);
         if (acc) begin
            done_c    = c + 2 + ws[r];
            busy_done = done_c;
            if (we) begin
               if (!ro[r]) st_q.push_back('{c + 1, 4'b0000, oh, a[13:0], wd});
            end else begin
               st_q.push_back('{c + 1, oh, 4'b0000, a[13:0], wd});
               t       = rd_tab[(done_c - 1) % 64];
               last_rd = t[16*r +: 16];
            end
            rd_q.push_back('{done_c, last_rd, a[13:0], wd});
         end
         m_err = (acc && we && ro[r]) || (m_err && !clr);
         m_ovr = ((re || we) && !acc) || (m_ovr && !clr);
         fl_q.push_back('{c + 1, m_err, m_ovr, 1'b0});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
   endtask

   fl_t fe;
   st_t se;
   rd_t re_e;

   always @(negedge clk) begin
      if (fl_q.size() > 0 && fl_q[0].cyc == cyc) begin
         fe = fl_q.pop_front();
         chk("bus_err", bus_err, fe.err);
         chk("bus_ovr", bus_ovr, fe.ovr);
         if (fe.rst) begin
            chk("rst_ready", cpu_ready, 0);
            chk("rst_rdata", cpu_rdata, 0);
            chk("rst_dev_re", dev_re, 0);
            chk("rst_dev_we", dev_we, 0);
            chk("rst_dev_addr", dev_addr, 0);
            chk("rst_dev_wdata", dev_wdata, 0);
         end
      end
      if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
         se = st_q.pop_front();
         chk("strobe_re", dev_re, se.re);
         chk("strobe_we", dev_we, se.we);
         chk("strobe_addr", dev_addr, se.addr);
         chk("strobe_wdata", dev_wdata, se.wdata);
      end else if (dev_re != 4'b0 || dev_we != 4'b0) begin
         chk("stray_strobe", {dev_re, dev_we}, 0);
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
         re_e = rd_q.pop_front();
         chk("ready", cpu_ready, 1);
         chk("ready_rdata", cpu_rdata, re_e.rdata);
         chk("done_addr", dev_addr, re_e.addr);
         chk("done_wdata", dev_wdata, re_e.wdata);
      end else if (cpu_ready) begin
         chk("stray_ready", cpu_ready, 0);
      end
   end

   initial begin
      for (int i = 0; i < 64; i++) rd_tab[i] = {$urandom, $urandom};
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      idle(2);
      // Zero-wait read, then write through a 3-wait region.
      step(1'b1, 1'b0, 16'h4005, 16'h0000, 1'b0, 1'b0);
      idle(6);
      step(1'b0, 1'b1, 16'h8010, 16'h1234, 1'b0, 1'b0);
      idle(8);
      // Read-only write, then clear.
      step(1'b0, 1'b1, 16'h4000, 16'h5555, 1'b0, 1'b0);
      idle(4);
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      idle(2);
      // Back-to-back reads: the second is dropped.
      step(1'b1, 1'b0, 16'h8000, 16'h0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 16'h8004, 16'h0, 1'b0, 1'b0);
      idle(8);
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      idle(2);
      // Read and write together act as a write.
      step(1'b1, 1'b1, 16'h0003, 16'hBEEF, 1'b0, 1'b0);
      idle(5);
      // Reset during WAIT, then a normal read.
      step(1'b1, 1'b0, 16'h8002, 16'h0, 1'b0, 1'b0);
      idle(1);
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 16'h8002, 16'h0, 1'b0, 1'b0);
      idle(8);
      // Set coinciding with clear: set wins for both flags.
      step(1'b0, 1'b1, 16'h4001, 16'h7777, 1'b1, 1'b0);
      idle(4);
      step(1'b1, 1'b0, 16'hC000, 16'h0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 16'h0, 1'b1, 1'b0);
      idle(6);
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              16'($urandom), 16'($urandom),
              $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
      end
      idle(20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
